ret_addr_stack: RTL and testbench

Return address stack (RAS) that serves return-target predictions to the branch status/fetch stage. It pushes return addresses for calls and pops them for returns detected in fetched instructions, and presents the top entry as `ret_v`/`ret_pc` for next-fetch-PC selection on BTB return hits. A second, commit-side copy of the stack is maintained from retired call/return jumps. On a pipeline flush caused by a mispredict, the speculative stack is restored from the committed copy.

---
 rtl/ret_addr_stack.sv | 134 +++++++++++++
 tb/tb_ret_addr_stack.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ret_addr_stack.sv
// Return address stack with a speculative fetch-side copy and a committed retire-side copy.
// A mispredict flush reloads the speculative copy from the committed copy, including this cycle's commit.
module ret_addr_stack #(
    parameter int ADDR      = 32,
    parameter int RAS_DEPTH = 8,
    parameter int RAS       = $clog2(RAS_DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            inst_e_,
    input  logic [ADDR-1:0] inst_pc,
    input  logic            inst_call_,
    input  logic            inst_return_,
    output logic            ret_v,
    output logic [ADDR-1:0] ret_pc,
    input  logic            jump_commit_,
    input  logic            jump_call_,
    input  logic            jump_return_,
    input  logic [ADDR-1:0] com_pc,
    input  logic            flush_
);

    localparam logic [RAS:0]    CNT_FULL = (RAS+1)'(RAS_DEPTH);
    localparam logic [RAS:0]    CNT_ONE  = (RAS+1)'(1);
    localparam logic [RAS:0]    CNT_ZERO = (RAS+1)'(0);
    localparam logic [RAS-1:0]  SP_ONE   = RAS'(1);
    localparam logic [RAS-1:0]  SP_ZERO  = RAS'(0);
    localparam logic [ADDR-1:0] PC_STEP  = ADDR'(4);
    localparam logic [ADDR-1:0] PC_ZERO  = ADDR'(0);

    typedef struct packed {
        logic           we;
        logic [RAS-1:0] widx;
        logic [RAS-1:0] sp;
        logic [RAS:0]   cnt;
    } stk_upd_t;

    // Shared pointer/count update rule; identical for both stacks.
    function automatic stk_upd_t stack_step(
        input logic           en,
        input logic           call,
        input logic           ret,
        input logic [RAS-1:0] sp,
        input logic [RAS:0]   cnt
    );
        stk_upd_t u;
        u.we   = 1'b0;
        u.widx = sp;
        u.sp   = sp;
        u.cnt  = cnt;
        if (en && call && (!ret || cnt == CNT_ZERO)) begin
            // plain push, or call+return on an empty stack which degenerates to a push
            u.we   = 1'b1;
            u.widx = sp;
            u.sp   = sp + SP_ONE;
            u.cnt  = (cnt == CNT_FULL) ? cnt : cnt + CNT_ONE;
        end else if (en && call && ret) begin
            u.we   = 1'b1;
            u.widx = sp - SP_ONE;
        end else if (en && ret && cnt != CNT_ZERO) begin
            u.sp  = sp - SP_ONE;
            u.cnt = cnt - CNT_ONE;
        end else begin
            u.we = 1'b0;
        end
        return u;
    endfunction

    logic [ADDR-1:0] spec_entry     [RAS_DEPTH];
    logic [ADDR-1:0] com_entry      [RAS_DEPTH];
    logic [ADDR-1:0] spec_entry_nxt [RAS_DEPTH];
    logic [ADDR-1:0] com_entry_nxt  [RAS_DEPTH];
    logic [RAS-1:0]  spec_sp;
    logic [RAS-1:0]  com_sp;
    logic [RAS:0]    spec_cnt;
    logic [RAS:0]    com_cnt;
    logic [RAS-1:0]  spec_sp_nxt;
    logic [RAS:0]    spec_cnt_nxt;
    stk_upd_t        spec_upd;
    stk_upd_t        com_upd;

    // Event decode for both stacks.
    always_comb begin
        spec_upd = stack_step(!inst_e_, !inst_call_, !inst_return_, spec_sp, spec_cnt);
        com_upd  = stack_step(!jump_commit_, !jump_call_, !jump_return_, com_sp, com_cnt);
    end

    // Next contents of both stacks; a flush discards the fetch event and copies the committed result.
    always_comb begin
        com_entry_nxt = com_entry;
        if (com_upd.we) begin
            com_entry_nxt[com_upd.widx] = com_pc + PC_STEP;
        end else begin
            com_entry_nxt = com_entry;
        end
        spec_entry_nxt = spec_entry;
        spec_sp_nxt    = spec_upd.sp;
        spec_cnt_nxt   = spec_upd.cnt;
        if (!flush_) begin
            spec_entry_nxt = com_entry_nxt;
            spec_sp_nxt    = com_upd.sp;
            spec_cnt_nxt   = com_upd.cnt;
        end else if (spec_upd.we) begin
            spec_entry_nxt[spec_upd.widx] = inst_pc + PC_STEP;
        end else begin
            spec_entry_nxt = spec_entry;
        end
    end

    // State registers for both stacks.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                spec_entry[i] <= PC_ZERO;
                com_entry[i]  <= PC_ZERO;
            end
            spec_sp  <= SP_ZERO;
            spec_cnt <= CNT_ZERO;
            com_sp   <= SP_ZERO;
            com_cnt  <= CNT_ZERO;
        end else begin
            spec_entry <= spec_entry_nxt;
            com_entry  <= com_entry_nxt;
            spec_sp    <= spec_sp_nxt;
            spec_cnt   <= spec_cnt_nxt;
            com_sp     <= com_upd.sp;
            com_cnt    <= com_upd.cnt;
        end
    end

    assign ret_v  = (spec_cnt != CNT_ZERO);
    assign ret_pc = spec_entry[spec_sp - SP_ONE];

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed self-checking bench for ret_addr_stack (ADDR=32, RAS_DEPTH=8).
module tb_ret_addr_stack;

    logic        clk = 1'b0;
    logic        reset_;
    logic        inst_e_;
    logic [31:0] inst_pc;
    logic        inst_call_;
    logic        inst_return_;
    logic        ret_v;
    logic [31:0] ret_pc;
    logic        jump_commit_;
    logic        jump_call_;
    logic        jump_return_;
    logic [31:0] com_pc;
    logic        flush_;

    int checks = 0;
    int errors = 0;

    ret_addr_stack #(.ADDR(32), .RAS_DEPTH(8)) dut (
        .clk(clk), .reset_(reset_),
        .inst_e_(inst_e_), .inst_pc(inst_pc), .inst_call_(inst_call_), .inst_return_(inst_return_),
        .ret_v(ret_v), .ret_pc(ret_pc),
        .jump_commit_(jump_commit_), .jump_call_(jump_call_), .jump_return_(jump_return_),
        .com_pc(com_pc), .flush_(flush_)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        inst_e_ = 1'b1; inst_call_ = 1'b1; inst_return_ = 1'b1; inst_pc = 32'h0;
        jump_commit_ = 1'b1; jump_call_ = 1'b1; jump_return_ = 1'b1; com_pc = 32'h0;
        flush_ = 1'b1;
    endtask

    // One clock with the given (active-high sense) fetch/commit/flush events, then back to idle.
    task automatic cyc(input logic fe, input logic fc, input logic fr, input logic [31:0] fpc,
                       input logic ce, input logic cc, input logic cr, input logic [31:0] cpc,
                       input logic fl);
        inst_e_ = !fe; inst_call_ = !fc; inst_return_ = !fr; inst_pc = fpc;
        jump_commit_ = !ce; jump_call_ = !cc; jump_return_ = !cr; com_pc = cpc;
        flush_ = !fl;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic fcall(input logic [31:0] pc);
        cyc(1'b1, 1'b1, 1'b0, pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic fret();
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] cnt_now();
        return 32'(dut.spec_cnt);
    endfunction

    initial begin
        idle();
        reset_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_v", {31'h0, ret_v}, 32'h0);
        chk("reset_pc", ret_pc, 32'h0);
        chk("reset_cnt", cnt_now(), 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        // basic push / pop
        fcall(32'h100);
        chk("push_v", {31'h0, ret_v}, 32'h1);
        chk("push_pc", ret_pc, 32'h104);
        fret();
        chk("pop_v", {31'h0, ret_v}, 32'h0);

        // overflow: 9 pushes into 8 entries, then 8 pops
        for (int i = 0; i < 9; i++) fcall(32'(i * 16));
        chk("ovf_cnt", cnt_now(), 32'h8);
        for (int k = 0; k < 8; k++) begin
            chk("ovf_seq", ret_pc, 32'(32'h84 - k * 16));
            fret();
        end
        chk("ovf_empty_v", {31'h0, ret_v}, 32'h0);
        chk("ovf_overwrite", ret_pc, 32'h84);

        // underflow leaves state untouched
        fret();
        chk("udf_v", {31'h0, ret_v}, 32'h0);
        chk("udf_cnt", cnt_now(), 32'h0);
        chk("udf_pc", ret_pc, 32'h84);
        fcall(32'h200);
        chk("udf_push_pc", ret_pc, 32'h204);
        chk("udf_push_cnt", cnt_now(), 32'h1);

        // call+return together replaces the top
        fret();
        fcall(32'h100);
        cyc(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("both_pc", ret_pc, 32'h304);
        chk("both_cnt", cnt_now(), 32'h1);
        fret();
        cyc(1'b1, 1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("both_empty_pc", ret_pc, 32'h604);
        chk("both_empty_cnt", cnt_now(), 32'h1);

        // flush restore from committed stack
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0);
        chk("indep_pc", ret_pc, 32'h604);
        chk("indep_cnt", cnt_now(), 32'h1);
        fcall(32'h200);
        fcall(32'h300);
        chk("spec_pc", ret_pc, 32'h304);
        chk("spec_cnt", cnt_now(), 32'h3);
        cyc(1'b1, 1'b1, 1'b0, 32'h500, 1'b1, 1'b1, 1'b0, 32'h400, 1'b1);
        chk("flush_pc", ret_pc, 32'h404);
        chk("flush_cnt", cnt_now(), 32'h2);
        fret();
        chk("flush_pop_pc", ret_pc, 32'h104);
        chk("flush_pop_v", {31'h0, ret_v}, 32'h1);

        // return address wraps at top of address space
        fcall(32'hFFFF_FFFC);
        chk("wrap_pc", ret_pc, 32'h0);
        chk("wrap_v", {31'h0, ret_v}, 32'h1);

        // asynchronous reset mid-operation
        #2;
        reset_ = 1'b0;
        #1;
        chk("areset_v", {31'h0, ret_v}, 32'h0);
        chk("areset_pc", ret_pc, 32'h0);
        chk("areset_cnt", cnt_now(), 32'h0);
        @(negedge clk);
        reset_ = 1'b1;
        fcall(32'h700);
        chk("post_reset_pc", ret_pc, 32'h704);
        chk("post_reset_cnt", cnt_now(), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
